// File: rtl/int8_quad_drain.sv
// rtl/int8_quad_drain.sv - buffers accumulator quads and drains them one lane per handshake
// Optional build macro INT8_QUAD_DRAIN_SAT_EN: clamp emitted lanes to signed int8, sign-extended.
module int8_quad_drain #(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_w,
  input  logic [DATA_BITS-1:0] in_x,
  input  logic [DATA_BITS-1:0] in_y,
  input  logic [DATA_BITS-1:0] in_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [1:0]           out_lane,
  output logic                 out_last,
  output logic [15:0]          quad_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [3:0][DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [1:0]                r_lane;
  logic [15:0]               r_quad_count;
  logic                      r_run;

  logic                 w_push;
  logic                 w_hs;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_lane_raw;
  logic [DATA_BITS-1:0] w_lane_out;

  // r_run keeps in_ready low until the first clock edge after reset release
  assign in_ready   = r_run && (r_count < FULL);
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid && in_ready;
  assign w_hs       = out_valid && out_ready;
  assign w_pop      = w_hs && (r_lane == 2'd3);
  assign w_lane_raw = r_mem[r_rd_ptr][r_lane];

`ifdef INT8_QUAD_DRAIN_SAT_EN
  localparam logic signed [DATA_BITS-1:0] SAT_MAX = DATA_BITS'(127);
  localparam logic signed [DATA_BITS-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    w_lane_out = w_lane_raw;
    if ($signed(w_lane_raw) > SAT_MAX) begin
      w_lane_out = SAT_MAX;
    end else if ($signed(w_lane_raw) < SAT_MIN) begin
      w_lane_out = SAT_MIN;
    end
  end
`else
  assign w_lane_out = w_lane_raw;
`endif

  assign out_data   = out_valid ? w_lane_out : '0;
  assign out_lane   = out_valid ? r_lane : 2'd0;
  assign out_last   = out_valid && (r_lane == 2'd3);
  assign quad_count = r_quad_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_lane       <= 2'd0;
      r_quad_count <= 16'd0;
    end else begin
      r_run <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      // 2-bit lane counter returns to 0 by itself on the lane-3 handshake
      if (w_hs) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
        r_quad_count <= r_quad_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_z, in_y, in_x, in_w};
    end
  end

endmodule

// File: tb/tb_int8_quad_drain.sv
// tb/tb_int8_quad_drain.sv - self-checking bench for int8_quad_drain against a lane-stream queue model
module tb_int8_quad_drain;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_w = '0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic [DW-1:0] in_z = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic [15:0]   quad_count;

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0] exp_qc = 16'd0;
  logic        rdy_en = 1'b0;
  int          pushed = 0;

  int8_quad_drain #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
    .quad_count(quad_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] v);
`ifdef INT8_QUAD_DRAIN_SAT_EN
    int s;
    s = $signed(v);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return DW'(s);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_quad(input int w, input int x, input int y, input int z);
    in_w = DW'(w);
    in_x = DW'(x);
    in_y = DW'(y);
    in_z = DW'(z);
  endtask

  task automatic set_rand_quad();
    set_quad(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endtask

  // Called at a falling edge: check outputs against the model, advance model, move to next falling edge
  task automatic cycle();
    int            occ;
    logic          e_ready;
    logic          e_valid;
    logic [1:0]    e_lane;
    logic [DW-1:0] head;
    occ     = (exp_q.size() + 3) / 4;
    e_ready = rdy_en && rst && (occ < DEPTH);
    e_valid = (occ != 0);
    e_lane  = 2'((4 - exp_q.size() % 4) % 4);
    head    = e_valid ? exp_q[0] : '0;
    chk("in_ready", DW'(in_ready), DW'(e_ready));
    chk("out_valid", DW'(out_valid), DW'(e_valid));
    chk("out_data", out_data, head);
    chk("out_lane", DW'(out_lane), DW'(e_valid ? e_lane : 2'd0));
    chk("out_last", DW'(out_last), DW'(e_valid && e_lane == 2'd3));
    chk("quad_count", DW'(quad_count), DW'(exp_qc));
    if (rst) begin
      if (e_valid && out_ready) begin
        void'(exp_q.pop_front());
        if (e_lane == 2'd3) exp_qc++;
      end
      if (in_valid && e_ready) begin
        exp_q.push_back(model_lane(in_w));
        exp_q.push_back(model_lane(in_x));
        exp_q.push_back(model_lane(in_y));
        exp_q.push_back(model_lane(in_z));
        pushed++;
      end
    end
    @(posedge clk);
    if (rst) rdy_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    repeat (2) cycle();
    rst = 1'b1;
    cycle();

    // Single quad 1,2,3,4 with out_ready held high
    set_quad(1, 2, 3, 4);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("single_quad_count", DW'(quad_count), DW'(1));

    // Fill to full with out_ready low, then release to let the fifth quad in
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pushed    = 0;
    for (int g = 0; g < 40 && pushed < 5; g++) begin
      set_rand_quad();
      out_ready = (g >= 8);
      cycle();
    end
    chk("fill_accepts", DW'(pushed), DW'(5));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (24) cycle();

    // Backpressure on quad 0x10..0x13
    set_quad(32'h10, 32'h11, 32'h12, 32'h13);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0);
      cycle();
    end
    chk("backpressure_drained", DW'(exp_q.size()), DW'(0));

    // Push on the lane-3 handshake at occupancy 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_rand_quad();
    cycle();
    set_rand_quad();
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    set_rand_quad();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("simul_occupancy", DW'((exp_q.size() + 3) / 4), DW'(2));
    repeat (10) cycle();

    // Random push/pop traffic wrapping the pointers many times
    pushed = 0;
    for (int i = 0; i < 240; i++) begin
      set_rand_quad();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (24) cycle();
    chk("random_pushes_ge10", DW'(pushed >= 10), DW'(1));

    // Reset after lane 1 with three quads buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rand_quad();
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_lane", DW'(out_lane), DW'(0));
    chk("rst_out_last", DW'(out_last), DW'(0));
    chk("rst_quad_count", DW'(quad_count), DW'(0));
    exp_q.delete();
    exp_qc = 16'd0;
    rdy_en = 1'b0;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b1;
    repeat (4) cycle();
    set_quad(5, 6, 7, 8);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();

    // Saturation-sensitive values
    set_quad(300, -300, 127, -128);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("final_quad_count", DW'(quad_count), DW'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
